// File: rtl/bufg_clk.sv
// ---------------------------------------------------------------------------
// bufg_clk
//   Glitch-free gated clock buffer with a pulse counter on the gated clock.
//   The enable request is captured on the falling edge of px_clk, so the
//   gated clock O can only start or stop while px_clk is low. Each enabled
//   rising edge is counted modulo DEPTH. A one-cycle terminal-count pulse
//   (tc) is raised after the count wraps from DEPTH-1 to 0.
//
// Parameters
//   DEPTH       gated clock pulses per count period
//   CNT_W       width of the pulse counter
//
// Ports
//   px_clk      in   single clock, also the buffer input
//   reset       in   synchronous active-high reset; posedge clears the
//                    counter and tc, negedge forces the enable on
//   ce          in   clock-enable request for the buffered clock
//   O           out  buffered, gated clock (px_clk AND applied enable)
//   ce_state    out  currently applied (latched) enable
//   pulse_count out  O rising edges counted in the current period
//   tc          out  terminal-count pulse, one cycle wide
// ---------------------------------------------------------------------------
module bufg_clk #(
  parameter int DEPTH = 76800,
  parameter int CNT_W = $clog2(DEPTH)
) (
  input  logic             px_clk,
  input  logic             reset,
  input  logic             ce,
  output logic             O,
  output logic             ce_state,
  output logic [CNT_W-1:0] pulse_count,
  output logic             tc
);

  localparam int unsigned LAST = DEPTH - 1;

  // Start-up values chosen so the clock runs before the first reset.
  logic             ce_q_r        = 1'b1;
  logic [CNT_W-1:0] pulse_count_r = {CNT_W{1'b0}};
  logic             tc_r          = 1'b0;

  logic [CNT_W-1:0] count_nxt_s;
  logic             tc_nxt_s;
  logic             at_last_s;
  logic             is_last_s;

  // Enable is captured on the falling edge so the AND gate below never
  // sees the enable change while px_clk is high (no runt pulses).
  always_ff @(negedge px_clk) begin
    if (reset) begin
      ce_q_r <= 1'b1;
    end else begin
      ce_q_r <= ce;
    end
  end

  // Clock path: a single AND gate, nothing else.
  assign O        = px_clk & ce_q_r;
  assign ce_state = ce_q_r;

  // The compare is done at 32 bits so a power-of-two DEPTH does not
  // truncate to zero at CNT_W bits. Values above LAST are unreachable, but
  // any such value is folded back to zero without raising tc.
  assign at_last_s = ({{(32-CNT_W){1'b0}}, pulse_count_r} >= LAST);
  assign is_last_s = ({{(32-CNT_W){1'b0}}, pulse_count_r} == LAST);

  // Next-state for the counter and terminal-count pulse.
  always_comb begin
    count_nxt_s = pulse_count_r;
    tc_nxt_s    = 1'b0;
    if (ce_q_r) begin
      if (at_last_s) begin
        count_nxt_s = {CNT_W{1'b0}};
        tc_nxt_s    = is_last_s;
      end else begin
        count_nxt_s = pulse_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        tc_nxt_s    = 1'b0;
      end
    end else begin
      count_nxt_s = pulse_count_r;
      tc_nxt_s    = 1'b0;
    end
  end

  // Counter and tc registers; reset abandons the period with no tc.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      pulse_count_r <= {CNT_W{1'b0}};
      tc_r          <= 1'b0;
    end else begin
      pulse_count_r <= count_nxt_s;
      tc_r          <= tc_nxt_s;
    end
  end

  assign pulse_count = pulse_count_r;
  assign tc          = tc_r;

endmodule

// File: tb/tb_bufg_clk.sv
module tb_bufg_clk;

  localparam int DA = 76800;
  localparam int DB = 4;

  logic        px_clk = 1'b0;
  logic        reset  = 1'b1;
  logic        ce     = 1'b0;
  logic        o_a, ce_state_a, tc_a;
  logic [16:0] pc_a;
  logic        o_b, ce_state_b, tc_b;
  logic [1:0]  pc_b;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic ce_m    = 1'b1;
  int   edges   = 0;     // enabled rising edges since last reset
  logic tcm_a   = 1'b0;
  logic tcm_b   = 1'b0;
  int   rises   = 0;     // observed O rising edges since last reset
  longint rise_t = 0;

  bufg_clk dut_a (
    .px_clk(px_clk), .reset(reset), .ce(ce),
    .O(o_a), .ce_state(ce_state_a), .pulse_count(pc_a), .tc(tc_a)
  );

  bufg_clk #(.DEPTH(DB)) dut_b (
    .px_clk(px_clk), .reset(reset), .ce(ce),
    .O(o_b), .ce_state(ce_state_b), .pulse_count(pc_b), .tc(tc_b)
  );

  always #5 px_clk = ~px_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Observed O rising edges, cleared by a reset edge.
  always @(posedge px_clk) if (reset) rises = 0;
  always @(posedge o_b) if (!reset) rises++;

  // Every high pulse on O must last exactly one px_clk high phase.
  always @(posedge o_b) rise_t = longint'($time);
  always @(negedge o_b) check("o_high_width", 32'(longint'($time) - rise_t), 32'd5);

  // Model update plus per-edge comparison.
  always begin
    @(posedge px_clk);
    if (reset) begin
      edges = 0; tcm_a = 1'b0; tcm_b = 1'b0;
    end else if (ce_m) begin
      edges++;
      tcm_a = ((edges % DA) == 0);
      tcm_b = ((edges % DB) == 0);
    end else begin
      tcm_a = 1'b0; tcm_b = 1'b0;
    end
    #1;
    check("m_pc_a", 32'(pc_a), 32'(edges % DA));
    check("m_pc_b", 32'(pc_b), 32'(edges % DB));
    check("m_tc_a", 32'(tc_a), 32'(tcm_a));
    check("m_tc_b", 32'(tc_b), 32'(tcm_b));
    check("m_o_hi_a", 32'(o_a), 32'(ce_m));
    check("m_o_hi_b", 32'(o_b), 32'(ce_m));
    check("m_ce_state", 32'(ce_state_b), 32'(ce_m));
    check("m_rises", 32'(pc_b), 32'(rises % DB));
    @(negedge px_clk);
    ce_m = reset ? 1'b1 : ce;
    #1;
    check("m_ce_state_neg", 32'(ce_state_a), 32'(ce_m));
    check("m_o_lo_a", 32'(o_a), 32'd0);
    check("m_o_lo_b", 32'(o_b), 32'd0);
  end

  // Directed stimulus with literal expectations.
  initial begin
    logic [1:0] seq_b [10];
    logic       seq_t [10];
    int d;
    seq_b = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    seq_t = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Power-up values before the first reset edge.
    #1;
    check("init_ce_state", 32'(ce_state_a), 32'd1);
    check("init_pc", 32'(pc_a), 32'd0);
    check("init_tc", 32'(tc_a), 32'd0);

    // Reset for two cycles with ce = 0: clock still runs.
    @(posedge px_clk); #1;
    check("rst_o_high", 32'(o_a), 32'd1);
    check("rst_pc", 32'(pc_a), 32'd0);
    @(negedge px_clk); #1;
    check("rst_ce_state", 32'(ce_state_a), 32'd1);
    check("rst_o_low", 32'(o_a), 32'd0);
    @(posedge px_clk); #1;
    check("rst_tc", 32'(tc_b), 32'd0);
    check("rst_o_high2", 32'(o_b), 32'd1);
    ce = 1'b1;
    reset = 1'b0;

    // Ten enabled edges: counts 1..10, DEPTH=4 instance wraps with tc.
    for (int i = 0; i < 10; i++) begin
      @(posedge px_clk); #1;
      check("run_pc_a", 32'(pc_a), 32'(i + 1));
      check("run_pc_b", 32'(pc_b), 32'(seq_b[i]));
      check("run_tc_b", 32'(tc_b), 32'(seq_t[i]));
      check("run_tc_a", 32'(tc_a), 32'd0);
    end

    // Drop ce while px_clk is high: O stays high until the falling edge.
    #1 ce = 1'b0;
    #1;
    check("stop_o_still_high", 32'(o_a), 32'd1);
    check("stop_ce_state_held", 32'(ce_state_a), 32'd1);
    @(negedge px_clk); #1;
    check("stop_ce_state", 32'(ce_state_a), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge px_clk); #1;
      check("stop_o_low", 32'(o_a), 32'd0);
      check("frz_pc_a", 32'(pc_a), 32'd10);
      check("frz_pc_b", 32'(pc_b), 32'd2);
      check("frz_tc_b", 32'(tc_b), 32'd0);
    end

    // Re-enable, reach 3 on DEPTH=4, then reset mid-period.
    ce = 1'b1;
    @(posedge px_clk); #1;
    check("pre_rst_pc_b", 32'(pc_b), 32'd3);
    check("pre_rst_pc_a", 32'(pc_a), 32'd11);
    reset = 1'b1;
    @(posedge px_clk); #1;
    check("mid_rst_pc_b", 32'(pc_b), 32'd0);
    check("mid_rst_tc_b", 32'(tc_b), 32'd0);
    check("mid_rst_pc_a", 32'(pc_a), 32'd0);
    reset = 1'b0;
    @(posedge px_clk); #1;
    check("restart_pc_b", 32'(pc_b), 32'd1);
    check("restart_tc_b", 32'(tc_b), 32'd0);

    // Random ce toggling, never exactly on a clock edge.
    for (int i = 0; i < 1000; i++) begin
      @(posedge px_clk);
      d = int'($urandom_range(1, 8));
      if (d >= 5) d = d + 1;
      #(d);
      ce = 1'($urandom_range(0, 1));
    end
    @(posedge px_clk); #1;
    check("end_rises", 32'(pc_a), 32'(rises % DA));
    @(posedge px_clk); #2;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bufg_clk.md
BUFG_CLK -- requirements
Module: bufg_clk

Interface
REQ-001 The block SHALL have parameter DEPTH, default 76800, meaning the number of gated clock pulses per count period.
REQ-002 The block SHALL have parameter CNT_W, default $clog2(DEPTH) (17), meaning the width of the pulse counter.
REQ-003 The block SHALL have port px_clk, input, 1 bit: the single clock; it is also the buffer input (I).
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on px_clk edges only.
REQ-005 The block SHALL have port ce, input, 1 bit: clock-enable request for the buffered clock.
REQ-006 The block SHALL have port O, output, 1 bit: the buffered, gated clock.
REQ-007 The block SHALL have port ce_state, output, 1 bit: the currently applied (latched) enable.
REQ-008 The block SHALL have port pulse_count, output, CNT_W bits: the number of O rising edges in the current period.
REQ-009 The block SHALL have port tc, output, 1 bit: terminal-count pulse.

Function
REQ-010 The block SHALL drive O = px_clk AND ce_q combinationally, with no other logic in the clock path.
REQ-011 The block SHALL update ce_q only on the falling edge of px_clk, capturing ce, so O can start or stop only while px_clk is low (glitch-free; no runt pulses).
REQ-012 When ce_q = 1, O SHALL be a zero-delay copy of px_clk (plain BUFG behaviour).
REQ-013 ce_state SHALL equal ce_q.
REQ-014 On each px_clk rising edge with ce_q = 1 and reset = 0, pulse_count SHALL increment by 1.
REQ-015 When pulse_count = DEPTH-1 on an enabled rising edge, pulse_count SHALL wrap to 0 and tc SHALL be 1 for that following cycle only.
REQ-016 tc SHALL be 0 on every other rising edge, including all edges with ce_q = 0.
REQ-017 When ce_q = 0, pulse_count SHALL hold its value.
REQ-018 A change of ce SHALL take effect at the next falling edge; the first counted rising edge after an enable is the first rising edge after that falling edge.
REQ-019 pulse_count arithmetic SHALL be unsigned CNT_W bits; values of DEPTH or above are unreachable, and if pulse_count is somehow >= DEPTH it SHALL be forced to 0 on the next enabled rising edge.

Reset
REQ-020 With reset = 1 at a px_clk rising edge, the block SHALL clear pulse_count to 0 and tc to 0.
REQ-021 With reset = 1 at a px_clk falling edge, the block SHALL set ce_q to 1, so that O runs immediately after reset regardless of ce.
REQ-022 Reset SHALL take priority over counting and over ce capture; a reset asserted mid-period SHALL abandon the count with no tc pulse.
REQ-023 Reset SHALL NOT block the clock path; O SHALL follow px_clk AND ce_q during reset.
REQ-024 Before the first reset, the simulation initial values SHALL be ce_q = 1, pulse_count = 0 and tc = 0.

Verification
REQ-025 Reset for 2 cycles with ce = 0 -> pulse_count = 0, tc = 0, ce_state = 1, and O toggles with px_clk.
REQ-026 Keep ce = 1 for 10 rising edges after reset -> pulse_count = 10 and O is identical to px_clk.
REQ-027 Drive ce low while px_clk is high -> O stays high until the px_clk falling edge, then stays low; ce_state falls at that falling edge; pulse_count freezes.
REQ-028 With DEPTH = 4 and ce = 1, apply 4 rising edges -> pulse_count sequence 1,2,3,0 and tc = 1 only in the cycle after the wrap.
REQ-029 With DEPTH = 4, assert reset at pulse_count = 3 -> pulse_count = 0, tc stays 0, and counting restarts from 1 after reset is released.
REQ-030 Toggle ce at random times for 1000 cycles -> O never shows a high pulse shorter than the px_clk high phase, and pulse_count mod DEPTH equals the number of O rising edges.
